// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame geometry and odd-parity helpers.
// Used by both the device transmitter and the host controller.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUS_CHECK,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_DONE,
    ST_ABORT
  } ps2_state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Wire order, LSB first: start(0), D0..D7, parity, stop(1).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for an asynchronous PS/2 line; resets high (idle line level).
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: drives the PS/2 clock and sends one 11-bit frame per accepted request,
// abandoning the frame if the host holds the clock low while the device has released it.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int HALF_CYC = 2000,
  parameter int IDLE_CYC = 2500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam int CNT_MAX = (HALF_CYC > IDLE_CYC) ? HALF_CYC : IDLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] INH_FIRST = CNT_W'(2);
  localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

  ps2_state_t            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [3:0]            bit_idx, bit_idx_n;
  logic [FRAME_BITS-1:0] frame, frame_n;
  logic                  clk_s;
  logic                  unused_data;

  // The data line is reserved for future host-to-device traffic.
  assign unused_data = ps2data_in;

  ps2_sync u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ps2clk_in),
    .q     (clk_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      frame   <= frame_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    frame_n    = frame;
    ps2clk_oe  = 1'b0;
    ps2data_oe = 1'b0;
    tx_done    = 1'b0;
    tx_abort   = 1'b0;
    busy       = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          frame_n = build_frame(tx_data);
          cnt_n   = '0;
          state_n = ST_BUS_CHECK;
        end
      end

      ST_BUS_CHECK: begin
        if (!clk_s) begin
          cnt_n = '0;
        end else if (cnt == IDLE_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = ST_BIT_HI;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // The first two cycles are skipped because our own released clock is still in the synchroniser.
      ST_BIT_HI: begin
        ps2data_oe = ~frame[bit_idx];
        if (!clk_s && cnt >= INH_FIRST) begin
          cnt_n   = '0;
          state_n = ST_ABORT;
        end else if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = ST_BIT_LO;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_BIT_LO: begin
        ps2clk_oe  = 1'b1;
        ps2data_oe = ~frame[bit_idx];
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (bit_idx == LAST_BIT) begin
            state_n = ST_DONE;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            state_n   = ST_BIT_HI;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_DONE: begin
        if (cnt == HALF_LAST) begin
          tx_done = 1'b1;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_ABORT: begin
        tx_abort = 1'b1;
        state_n  = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: time-based reference model compared every cycle, plus directed and random frames.
module tb_ps2_device_tx;

  localparam int H  = 4;
  localparam int IC = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic       host_pull = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2clk_oe, ps2data_oe, busy, tx_done, tx_abort;

  // Open-drain lines with pull-ups; the host may also pull the clock low.
  wire ps2clk_in  = !(ps2clk_oe || host_pull);
  wire ps2data_in = !ps2data_oe;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_abort = 0;
  int ncap = 0;
  logic [10:0] cap = '0;

  ps2_device_tx #(.HALF_CYC(H), .IDLE_CYC(IC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Host receiver: shifts in the data line on each device-generated falling clock edge.
  always @(negedge ps2clk_in) begin
    if (!host_pull && rst_n) begin
      cap = {ps2data_in, cap[10:1]};
      ncap++;
    end
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) n_done++;
    if (tx_abort === 1'b1) n_abort++;
  end

  // Reference model: frame expressed as elapsed time m_t since the first clock-high half.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  int          m_mode;   // 0 idle, 1 waiting for quiet bus, 2 framing, 3 abort pulse
  int          m_run;
  int          m_t;
  int          m_bit;
  logic [10:0] m_frame;
  logic [1:0]  m_sy;
  logic        m_cs;
  logic        e_busy, e_clk, e_dat, e_done, e_abort;

  always_comb begin
    m_bit   = (m_t / (2 * H) > 10) ? 10 : m_t / (2 * H);
    e_busy  = (m_mode != 0);
    e_abort = (m_mode == 3);
    e_clk   = (m_mode == 2) && (m_t < 22 * H) && ((m_t / H) % 2 == 1);
    e_dat   = (m_mode == 2) && (m_t < 22 * H) && !m_frame[m_bit];
    e_done  = (m_mode == 2) && (m_t == 23 * H - 1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_run  = 0;
      m_t    = 0;
      m_sy   = 2'b11;
    end else begin
      m_cs = m_sy[1];
      m_sy = {m_sy[0], !(e_clk || host_pull)};
      case (m_mode)
        0: if (tx_start) begin
          m_frame = frame_of(tx_data);
          m_run   = 0;
          m_mode  = 1;
        end
        1: if (!m_cs) m_run = 0;
           else if (m_run == IC - 1) begin m_mode = 2; m_t = 0; end
           else m_run++;
        2: if (m_t < 22 * H && (m_t / H) % 2 == 0 && m_t % H >= 2 && !m_cs) m_mode = 3;
           else if (m_t == 23 * H - 1) m_mode = 0;
           else m_t++;
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    n_chk++;
    if ({busy, ps2clk_oe, ps2data_oe, tx_done, tx_abort} !== {e_busy, e_clk, e_dat, e_done, e_abort}) begin
      n_err++;
      $display("FAIL cycle_cmp cyc=%0d got busy/clk/dat/done/abort=%b expected=%b", cyc,
               {busy, ps2clk_oe, ps2data_oe, tx_done, tx_abort}, {e_busy, e_clk, e_dat, e_done, e_abort});
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s timeout got=waiting expected=event", name);
  endtask

  task automatic send(input logic [7:0] d, output int s_cyc);
    @(posedge clk);
    #1 tx_data = d;
    tx_start = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #1 tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) timeout(name);
  endtask

  task automatic wait_caps(input string name, input int target);
    int n;
    n = 0;
    while (ncap < target && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) timeout(name);
  endtask

  task automatic wait_clk_oe(input string name, input logic lvl, output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (ps2clk_oe !== lvl && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) timeout(name);
    at = cyc;
  endtask

  initial begin
    int s, at, base, d0, a0, r;
    logic [10:0] first;

    // Literal pins on the model's frame builder.
    check("model_frame_fa", 32'(frame_of(8'hFA)), 32'h7F4);
    check("model_frame_00", 32'(frame_of(8'h00)), 32'h600);
    check("model_frame_ff", 32'(frame_of(8'hFF)), 32'h7FE);
    check("model_frame_01", 32'(frame_of(8'h01)), 32'h402);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {29'd0, busy, ps2clk_oe, ps2data_oe}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: single byte
    base = ncap; d0 = n_done;
    send(8'hFA, s);
    wait_idle("t1_idle");
    check("t1_frame", 32'(cap), 32'h7F4);
    check("t1_bits", ncap - base, 11);
    check("t1_done", n_done - d0, 1);
    check("t1_busy_after", 32'(busy), 0);

    // 2: back-to-back bytes
    base = ncap; d0 = n_done;
    send(8'h00, s);
    wait_idle("t2a_idle");
    first = cap;
    send(8'hFF, s);
    wait_idle("t2b_idle");
    check("t2_parity_00", 32'(first[9]), 1);
    check("t2_parity_ff", 32'(cap[9]), 1);
    check("t2_stop_ff", 32'(cap[10]), 1);
    check("t2_frame_ff", 32'(cap), 32'h7FE);
    check("t2_dones", n_done - d0, 2);

    // 3: parity 0 and first falling edge not before 8 cycles
    send(8'h01, s);
    wait_clk_oe("t3_fall", 1'b1, at);
    check("t3_fall_ge8", 32'(at - s >= 8), 1);
    wait_idle("t3_idle");
    check("t3_parity", 32'(cap[9]), 0);
    check("t3_frame", 32'(cap), 32'h402);

    // 4: host inhibits before the request and releases 20 cycles later
    @(posedge clk);
    #1 host_pull = 1'b1;
    repeat (3) @(posedge clk);
    send(8'h5A, s);
    repeat (19) @(posedge clk);
    #1 host_pull = 1'b0;
    r = cyc;
    wait_clk_oe("t4_first_low", 1'b1, at);
    check("t4_bit_hi_start", at - r - H, 8);
    wait_idle("t4_idle");
    check("t4_frame", 32'(cap), 32'(frame_of(8'h5A)));

    // 5: inhibit during clock-high half of bit 4
    base = ncap; d0 = n_done; a0 = n_abort;
    send(8'hC3, s);
    wait_caps("t5_bits", base + 4);
    wait_clk_oe("t5_bit4_hi", 1'b0, at);
    @(posedge clk);
    #1 host_pull = 1'b1;
    wait_idle("t5_idle");
    check("t5_abort", n_abort - a0, 1);
    check("t5_no_done", n_done - d0, 0);
    check("t5_lines", {30'd0, ps2clk_oe, ps2data_oe}, 0);
    check("t5_bits_sent", ncap - base, 4);
    repeat (3) @(posedge clk);
    #1 host_pull = 1'b0;
    repeat (4) @(posedge clk);

    // 6: asynchronous reset in bit 6, then a full frame
    base = ncap; d0 = n_done; a0 = n_abort;
    send(8'h96, s);
    wait_caps("t6_bits", base + 7);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset", {29'd0, busy, ps2clk_oe, ps2data_oe}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t6_no_pulses", (n_done - d0) + (n_abort - a0), 0);
    r = $urandom_range(0, 255);
    base = ncap;
    send(8'(r), s);
    wait_idle("t6_idle");
    check("t6_frame", 32'(cap), 32'(frame_of(8'(r))));
    check("t6_bits", ncap - base, 11);

    // 7: requests while busy and in the cycle busy falls are ignored
    send(8'h3C, s);
    repeat (15) @(posedge clk);
    #1 tx_data = 8'hA5;
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    at = 0;
    while (tx_done !== 1'b1 && at < 400) begin @(negedge clk); at++; end
    if (at >= 400) timeout("t7_done");
    tx_data = 8'h11;
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    check("t7_frame", 32'(cap), 32'(frame_of(8'h3C)));
    @(negedge clk);
    check("t7_fall_ignored", 32'(busy), 0);

    // Random bytes, gaps and occasional host inhibit pulses.
    for (int k = 0; k < 10; k++) begin
      int gap, glitch, dly;
      r = $urandom_range(0, 255);
      gap = $urandom_range(0, 5);
      glitch = ($urandom_range(0, 2) == 0);
      dly = $urandom_range(5, 90);
      repeat (gap) @(posedge clk);
      a0 = n_abort;
      fork
        begin
          send(8'(r), s);
          wait_idle("rand_idle");
        end
        begin
          if (glitch != 0) begin
            repeat (dly) @(posedge clk);
            #1 host_pull = 1'b1;
            repeat (3) @(posedge clk);
            #1 host_pull = 1'b0;
          end
        end
      join
      if (glitch == 0) check("rand_frame", 32'(cap), 32'(frame_of(8'(r))));
      repeat (4) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1);
  end

endmodule
